// File: rtl/mlp_batch_scheduler.sv
// Batch scheduler for the MLP inference controller.
// Walks a batch of stored test samples: launches one inference per sample,
// waits for completion (with a timeout), reads the sample's label and keeps
// running counts of tests run and correct predictions.
module mlp_batch_scheduler #(
    parameter int NUM_TESTS = 750,
    parameter int TEST_W    = 10,
    parameter int CLASS_W   = 4,
    parameter int TIMEOUT   = 2047
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               batch_start,
    input  logic [TEST_W-1:0]  batch_len,
    output logic               mlp_start,
    output logic [TEST_W-1:0]  mlp_test_num,
    input  logic               mlp_done,
    input  logic [CLASS_W-1:0] pred_class,
    output logic               label_rd,
    output logic [TEST_W-1:0]  label_addr,
    input  logic [CLASS_W-1:0] label_data,
    output logic [TEST_W-1:0]  tested_cnt,
    output logic [TEST_W-1:0]  correct_cnt,
    output logic               busy,
    output logic               batch_done,
    output logic               timeout_err
);

    localparam int                 WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [TEST_W-1:0]  MAX_LEN   = TEST_W'(NUM_TESTS);
    // Last wait count before giving up: the FSM spends TIMEOUT cycles in WAIT_DONE.
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_FETCH_LBL = 3'd3,
        S_COMPARE   = 3'd4,
        S_NEXT      = 3'd5,
        S_FINISH    = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    state_t              state;
    logic [TEST_W-1:0]   idx;
    logic [TEST_W-1:0]   len;
    logic [CLASS_W-1:0]  pred_q;
    logic [WAIT_W-1:0]   wait_cnt;

    // The test index register drives the controller's sample address directly,
    // so it stays stable from LAUNCH until NEXT advances it.
    assign mlp_test_num = idx;

    // Batch FSM with registered outputs: every pulse output is set on the
    // transition into the state that owns it and cleared by default otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= {TEST_W{1'b0}};
            len         <= {TEST_W{1'b0}};
            pred_q      <= {CLASS_W{1'b0}};
            wait_cnt    <= {WAIT_W{1'b0}};
            mlp_start   <= 1'b0;
            label_rd    <= 1'b0;
            label_addr  <= {TEST_W{1'b0}};
            tested_cnt  <= {TEST_W{1'b0}};
            correct_cnt <= {TEST_W{1'b0}};
            busy        <= 1'b0;
            batch_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            mlp_start  <= 1'b0;
            label_rd   <= 1'b0;
            label_addr <= {TEST_W{1'b0}};
            batch_done <= 1'b0;
            case (state)
                S_IDLE, S_ERROR: begin
                    if (batch_start) begin
                        len         <= (batch_len > MAX_LEN) ? MAX_LEN : batch_len;
                        idx         <= {TEST_W{1'b0}};
                        tested_cnt  <= {TEST_W{1'b0}};
                        correct_cnt <= {TEST_W{1'b0}};
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        if (batch_len == {TEST_W{1'b0}}) begin
                            state      <= S_FINISH;
                            batch_done <= 1'b1;
                        end else begin
                            state     <= S_LAUNCH;
                            mlp_start <= 1'b1;
                        end
                    end else begin
                        state <= state;
                    end
                end
                S_LAUNCH: begin
                    wait_cnt <= {WAIT_W{1'b0}};
                    state    <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // A completion in the final wait cycle still counts.
                    if (mlp_done) begin
                        pred_q     <= pred_class;
                        label_rd   <= 1'b1;
                        label_addr <= idx;
                        state      <= S_FETCH_LBL;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_FETCH_LBL: begin
                    // Synchronous label RAM: data arrives during COMPARE.
                    state <= S_COMPARE;
                end
                S_COMPARE: begin
                    tested_cnt <= tested_cnt + TEST_W'(1);
                    if (label_data == pred_q) begin
                        correct_cnt <= correct_cnt + TEST_W'(1);
                    end else begin
                        correct_cnt <= correct_cnt;
                    end
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (idx == len - TEST_W'(1)) begin
                        batch_done <= 1'b1;
                        state      <= S_FINISH;
                    end else begin
                        idx       <= idx + TEST_W'(1);
                        mlp_start <= 1'b1;
                        state     <= S_LAUNCH;
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_batch_scheduler.sv
// Directed testbench for mlp_batch_scheduler: behavioural MLP responder and
// label RAM models, one task per scenario, hand-computed expectations.
module tb_mlp_batch_scheduler;

    localparam int NT = 750;
    localparam int TW = 10;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- main DUT (default TIMEOUT) ----------------
    logic          batch_start = 1'b0;
    logic [TW-1:0] batch_len = '0;
    logic          mlp_start;
    logic [TW-1:0] mlp_test_num;
    logic          mlp_done;
    logic [CW-1:0] pred_class;
    logic          label_rd;
    logic [TW-1:0] label_addr;
    logic [CW-1:0] label_data = '0;
    logic [TW-1:0] tested_cnt;
    logic [TW-1:0] correct_cnt;
    logic          busy;
    logic          batch_done;
    logic          timeout_err;

    mlp_batch_scheduler dut (
        .clk(clk), .rst(rst), .batch_start(batch_start), .batch_len(batch_len),
        .mlp_start(mlp_start), .mlp_test_num(mlp_test_num), .mlp_done(mlp_done),
        .pred_class(pred_class), .label_rd(label_rd), .label_addr(label_addr),
        .label_data(label_data), .tested_cnt(tested_cnt), .correct_cnt(correct_cnt),
        .busy(busy), .batch_done(batch_done), .timeout_err(timeout_err)
    );

    // ---------------- second DUT with a short timeout ----------------
    logic          batch_start2 = 1'b0;
    logic [TW-1:0] batch_len2 = '0;
    logic          mlp_start2;
    logic [TW-1:0] mlp_test_num2;
    logic          mlp_done2;
    logic [CW-1:0] pred_class2;
    logic          label_rd2;
    logic [TW-1:0] label_addr2;
    logic [CW-1:0] label_data2 = '0;
    logic [TW-1:0] tested_cnt2;
    logic [TW-1:0] correct_cnt2;
    logic          busy2;
    logic          batch_done2;
    logic          timeout_err2;

    mlp_batch_scheduler #(.TIMEOUT(15)) dut_to (
        .clk(clk), .rst(rst), .batch_start(batch_start2), .batch_len(batch_len2),
        .mlp_start(mlp_start2), .mlp_test_num(mlp_test_num2), .mlp_done(mlp_done2),
        .pred_class(pred_class2), .label_rd(label_rd2), .label_addr(label_addr2),
        .label_data(label_data2), .tested_cnt(tested_cnt2), .correct_cnt(correct_cnt2),
        .busy(busy2), .batch_done(batch_done2), .timeout_err(timeout_err2)
    );

    // ---------------- models ----------------
    logic [CW-1:0] label_mem [0:NT-1];
    logic [CW-1:0] pred_mem  [0:NT-1];
    int            dly = 20;
    logic          force_done = 1'b0;
    int            cnt;
    logic [TW-1:0] cur_tn;
    logic          en2 = 1'b0;
    int            cnt2;

    // MLP responder: completes dly cycles after each start pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 0;
            cur_tn <= '0;
        end else if (mlp_start) begin
            cnt    <= dly;
            cur_tn <= mlp_test_num;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end
    assign mlp_done   = (cnt == 1) || force_done;
    assign pred_class = pred_mem[cur_tn];

    // Synchronous label RAM.
    always @(posedge clk) begin
        if (label_rd) label_data <= label_mem[label_addr];
    end

    // Responder for the short-timeout DUT; can be muted with en2.
    always @(posedge clk or posedge rst) begin
        if (rst) cnt2 <= 0;
        else if (mlp_start2) cnt2 <= 3;
        else if (cnt2 != 0) cnt2 <= cnt2 - 1;
    end
    assign mlp_done2   = en2 && (cnt2 == 1);
    assign pred_class2 = 4'd3;
    always @(posedge clk) begin
        if (label_rd2) label_data2 <= 4'd3;
    end

    // Event monitors (cumulative; tasks work with deltas).
    int            n_start = 0, n_done = 0, n_lrd = 0, n_unstable = 0, n_done2 = 0;
    logic [TW-1:0] h0 = '0, h1 = '0, h2 = '0;
    always @(posedge clk) begin
        if (!rst) begin
            if (mlp_start) begin
                n_start <= n_start + 1;
                h0 <= mlp_test_num;
                h1 <= h0;
                h2 <= h1;
            end
            if (batch_done)  n_done  <= n_done + 1;
            if (label_rd)    n_lrd   <= n_lrd + 1;
            if (batch_done2) n_done2 <= n_done2 + 1;
            if (cnt != 0 && !mlp_start && mlp_test_num != cur_tn) n_unstable <= n_unstable + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic start_batch(input logic [TW-1:0] len);
        @(negedge clk);
        batch_len   = len;
        batch_start = 1'b1;
        @(negedge clk);
        batch_start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (batch_done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_starts(input int target, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (n_start >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [44:0] outs;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        outs = {mlp_start, mlp_test_num, label_rd, label_addr, tested_cnt,
                correct_cnt, busy, batch_done, timeout_err};
        checks++;
        if (outs !== 45'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int s0, d0, l0, u0;
        bit ok;
        s0 = n_start; d0 = n_done; l0 = n_lrd; u0 = n_unstable;
        dly = 20;
        start_batch(10'd3);
        wait_done(400, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL basic_done: got %0d expected 1", ok); end
        checks++;
        if (tested_cnt !== 10'd3) begin errors++; $display("FAIL basic_tested: got %0d expected 3", tested_cnt); end
        checks++;
        if (correct_cnt !== 10'd2) begin errors++; $display("FAIL basic_correct: got %0d expected 2", correct_cnt); end
        @(negedge clk);
        checks++;
        if (n_start - s0 !== 3) begin errors++; $display("FAIL basic_starts: got %0d expected 3", n_start - s0); end
        checks++;
        if ({h2, h1, h0} !== {10'd0, 10'd1, 10'd2}) begin
            errors++; $display("FAIL basic_test_nums: got %0d,%0d,%0d expected 0,1,2", h2, h1, h0);
        end
        checks++;
        if (n_done - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", n_done - d0); end
        checks++;
        if (n_lrd - l0 !== 3) begin errors++; $display("FAIL basic_label_reads: got %0d expected 3", n_lrd - l0); end
        checks++;
        if (n_unstable - u0 !== 0) begin errors++; $display("FAIL basic_test_num_stable: got %0d expected 0", n_unstable - u0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %0d expected 0", busy); end
    endtask

    task automatic test_zero_len();
        int s0, l0;
        s0 = n_start; l0 = n_lrd;
        start_batch(10'd0);
        checks++;
        if ({batch_done, busy} !== 2'b11) begin
            errors++; $display("FAIL zero_done_pulse: got done=%0d busy=%0d expected 1 1", batch_done, busy);
        end
        @(negedge clk);
        checks++;
        if ({batch_done, busy} !== 2'b00) begin
            errors++; $display("FAIL zero_after: got done=%0d busy=%0d expected 0 0", batch_done, busy);
        end
        checks++;
        if ({tested_cnt, correct_cnt} !== 20'd0) begin
            errors++; $display("FAIL zero_counts: got %0d/%0d expected 0/0", tested_cnt, correct_cnt);
        end
        checks++;
        if ((n_start - s0) !== 0 || (n_lrd - l0) !== 0) begin
            errors++; $display("FAIL zero_no_activity: got starts=%0d reads=%0d expected 0 0", n_start - s0, n_lrd - l0);
        end
    endtask

    task automatic test_clamp();
        int s0;
        bit ok;
        s0 = n_start;
        dly = 2;
        start_batch(10'd1000);
        wait_done(20000, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL clamp_done: got %0d expected 1", ok); end
        checks++;
        if (tested_cnt !== 10'd750) begin errors++; $display("FAIL clamp_tested: got %0d expected 750", tested_cnt); end
        checks++;
        if (correct_cnt !== 10'd500) begin errors++; $display("FAIL clamp_correct: got %0d expected 500", correct_cnt); end
        checks++;
        if (h0 !== 10'd749) begin errors++; $display("FAIL clamp_last_num: got %0d expected 749", h0); end
        checks++;
        if (n_start - s0 !== 750) begin errors++; $display("FAIL clamp_starts: got %0d expected 750", n_start - s0); end
    endtask

    task automatic test_timeout();
        int d0;
        bit ok;
        d0 = n_done2;
        en2 = 1'b0;
        @(negedge clk);
        batch_len2   = 10'd2;
        batch_start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        batch_start2 = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if ({timeout_err2, busy2} !== 2'b01) begin
            errors++; $display("FAIL timeout_early: got err=%0d busy=%0d expected 0 1", timeout_err2, busy2);
        end
        @(negedge clk);
        checks++;
        if ({timeout_err2, busy2} !== 2'b10) begin
            errors++; $display("FAIL timeout_set: got err=%0d busy=%0d expected 1 0", timeout_err2, busy2);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (n_done2 - d0 !== 0) begin errors++; $display("FAIL timeout_no_done: got %0d expected 0", n_done2 - d0); end
        // Restart from ERROR with a responsive controller.
        en2 = 1'b1;
        batch_len2   = 10'd2;
        batch_start2 = 1'b1;
        @(negedge clk);
        batch_start2 = 1'b0;
        checks++;
        if ({timeout_err2, busy2} !== 2'b01) begin
            errors++; $display("FAIL timeout_restart: got err=%0d busy=%0d expected 0 1", timeout_err2, busy2);
        end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (batch_done2) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (ok !== 1'b1 || tested_cnt2 !== 10'd2 || correct_cnt2 !== 10'd2) begin
            errors++; $display("FAIL timeout_rerun: got done=%0d tested=%0d correct=%0d expected 1 2 2", ok, tested_cnt2, correct_cnt2);
        end
    endtask

    task automatic test_ignore();
        int s0;
        bit ok;
        s0 = n_start;
        dly = 5;
        start_batch(10'd4);
        wait_starts(s0 + 2, 200, ok);
        // Second batch request while busy.
        batch_len   = 10'd7;
        batch_start = 1'b1;
        @(negedge clk);
        batch_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (label_rd) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        force_done = 1'b1;   // spurious completion during COMPARE
        @(negedge clk);
        force_done = 1'b0;
        wait_done(300, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL ignore_done: got %0d expected 1", ok); end
        checks++;
        if (tested_cnt !== 10'd4 || correct_cnt !== 10'd3) begin
            errors++; $display("FAIL ignore_counts: got %0d/%0d expected 4/3", tested_cnt, correct_cnt);
        end
        @(negedge clk);
        checks++;
        if (n_start - s0 !== 4) begin errors++; $display("FAIL ignore_starts: got %0d expected 4", n_start - s0); end
    endtask

    task automatic test_reset_mid();
        int s0;
        bit ok;
        logic [44:0] outs;
        s0 = n_start;
        dly = 20;
        start_batch(10'd10);
        wait_starts(s0 + 5, 600, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (ok !== 1'b1 || tested_cnt !== 10'd4 || mlp_test_num !== 10'd4) begin
            errors++; $display("FAIL midreset_pre: got ok=%0d tested=%0d num=%0d expected 1 4 4", ok, tested_cnt, mlp_test_num);
        end
        rst = 1'b1;
        #1;
        outs = {mlp_start, mlp_test_num, label_rd, label_addr, tested_cnt,
                correct_cnt, busy, batch_done, timeout_err};
        checks++;
        if (outs !== 45'd0) begin errors++; $display("FAIL midreset_outputs: got %h expected 0", outs); end
        @(negedge clk);
        rst = 1'b0;
        s0 = n_start;
        repeat (40) @(negedge clk);
        checks++;
        if (n_start !== s0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_idle: got starts=%0d busy=%0d expected 0 0", n_start - s0, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < NT; i++) begin
            label_mem[i] = CW'(i % 10);
            pred_mem[i]  = (i % 3 == 1) ? CW'((i + 1) % 10) : CW'(i % 10);
        end
        test_reset();
        test_basic();
        test_zero_len();
        test_clamp();
        test_timeout();
        test_ignore();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
